// File: rtl/risk_sequencer.sv
// Hazard detection and run-control sequencer for the 5-stage pipeline.
// Define RISK_STATS_EN to add saturating stall/flush/cycle counters.
module risk_sequencer #(
   parameter int NB_REG     = 5,
   parameter int PIPE_DRAIN = 4
`ifdef RISK_STATS_EN
  ,parameter int NB_CNT     = 16
`endif
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_enable,
   input  logic              i_step,
   input  logic [NB_REG-1:0] i_id_rs,
   input  logic [NB_REG-1:0] i_id_rt,
   input  logic              i_id_branch,
   input  logic              i_take_branch,
   input  logic              i_id_halt,
   input  logic              i_ex_mem_read,
   input  logic              i_ex_reg_write,
   input  logic [NB_REG-1:0] i_ex_rd,
   input  logic              i_mem_mem_read,
   input  logic [NB_REG-1:0] i_mem_rd,
   output logic              o_risk,
   output logic              o_pc_write,
   output logic              o_ifid_write,
   output logic              o_ifid_flush,
   output logic              o_pipe_enable,
   output logic              o_halted
`ifdef RISK_STATS_EN
  ,output logic [NB_CNT-1:0] o_stall_cnt,
   output logic [NB_CNT-1:0] o_flush_cnt,
   output logic [NB_CNT-1:0] o_cycle_cnt
`endif
);

   localparam int NB_DRN = (PIPE_DRAIN < 2) ? 1 : $clog2(PIPE_DRAIN);
   localparam logic [NB_DRN-1:0] DRN_LOAD = NB_DRN'(PIPE_DRAIN - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_STEP,
      ST_DRAIN,
      ST_HALTED
   } state_t;

   state_t            state;
   logic [NB_DRN-1:0] drain_cnt;
   logic              step_q;
   logic              halted_q;

   logic step_pulse;
   logic active;
   logic draining;
   logic load_use;
   logic br_ex;
   logic br_mem;
   logic stall;
   logic halt_go;
   logic advance;

   function automatic logic match(input logic [NB_REG-1:0] x,
                                  input logic [NB_REG-1:0] rs,
                                  input logic [NB_REG-1:0] rt);
      return (x != '0) && ((x == rs) || (x == rt));
   endfunction

   always_comb begin
      step_pulse = i_step & ~step_q;
      active     = (state == ST_RUN) || (state == ST_STEP);
      draining   = (state == ST_DRAIN);
      load_use   = i_ex_mem_read & match(i_ex_rd, i_id_rs, i_id_rt);
      br_ex      = i_id_branch & i_ex_reg_write
                   & match(i_ex_rd, i_id_rs, i_id_rt);
      br_mem     = i_id_branch & i_mem_mem_read
                   & match(i_mem_rd, i_id_rs, i_id_rt);
      stall      = active & (load_use | br_ex | br_mem);
      halt_go    = active & ~stall & i_id_halt;
      advance    = active & ~stall & ~i_id_halt;
   end

   // Stall wins over halt and flush; HALT itself proceeds into ID/EX.
   always_comb begin
      o_pipe_enable = active | draining;
      o_risk        = stall | draining;
      o_pc_write    = advance;
      o_ifid_write  = advance;
      o_ifid_flush  = advance & i_take_branch;
      o_halted      = halted_q;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
         step_q    <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         step_q <= i_step;
         unique case (state)
            ST_IDLE: begin
               if (i_enable)
                  state <= ST_RUN;
               else if (step_pulse)
                  state <= ST_STEP;
            end
            ST_RUN, ST_STEP: begin
               if (halt_go) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DRN_LOAD;
               end else if (state == ST_STEP || !i_enable) begin
                  state <= ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == '0) begin
                  state    <= ST_HALTED;
                  halted_q <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            ST_HALTED: state <= ST_HALTED;
            default:   state <= ST_IDLE;
         endcase
      end
   end

`ifdef RISK_STATS_EN
   logic frozen;

   assign frozen = (state == ST_HALTED);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
         o_cycle_cnt <= '0;
      end else if (!frozen) begin
         if (stall && !(&o_stall_cnt))
            o_stall_cnt <= o_stall_cnt + 1'b1;
         if (o_ifid_flush && !(&o_flush_cnt))
            o_flush_cnt <= o_flush_cnt + 1'b1;
         if (o_pipe_enable && !(&o_cycle_cnt))
            o_cycle_cnt <= o_cycle_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_risk_sequencer.sv
// Directed plus random stimulus for risk_sequencer, checked against a
// behavioural model of run mode, drain countdown and hazard rules.
module tb_risk_sequencer;

   localparam int NB_REG     = 5;
   localparam int PIPE_DRAIN = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, en, step, br, tk, hlt;
   logic              exmr, exrw, mmr;
   logic [NB_REG-1:0] rs, rt, exrd, mrd;
   logic              risk, pcw, ifw, fl, pe, hd;
`ifdef RISK_STATS_EN
   logic [15:0]       c_stall, c_flush, c_cycle;
`endif

   risk_sequencer #(.NB_REG(NB_REG), .PIPE_DRAIN(PIPE_DRAIN)) dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_enable      (en),
      .i_step        (step),
      .i_id_rs       (rs),
      .i_id_rt       (rt),
      .i_id_branch   (br),
      .i_take_branch (tk),
      .i_id_halt     (hlt),
      .i_ex_mem_read (exmr),
      .i_ex_reg_write(exrw),
      .i_ex_rd       (exrd),
      .i_mem_mem_read(mmr),
      .i_mem_rd      (mrd),
      .o_risk        (risk),
      .o_pc_write    (pcw),
      .o_ifid_write  (ifw),
      .o_ifid_flush  (fl),
      .o_pipe_enable (pe),
      .o_halted      (hd)
`ifdef RISK_STATS_EN
     ,.o_stall_cnt   (c_stall),
      .o_flush_cnt   (c_flush),
      .o_cycle_cnt   (c_cycle)
`endif
   );

   int errors = 0;
   int checks = 0;

   // Model: running/stepping flags, remaining drain cycles, halted flag.
   bit m_run, m_step, m_halt, m_stepq;
   int m_drain;
   int m_nstall, m_nflush, m_ncycle;
   bit e_risk, e_pcw, e_ifw, e_fl, e_pe, e_hd, e_stall;

   task automatic chk(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chkv(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit uses(logic [NB_REG-1:0] r);
      return r != 0 && (r == rs || r == rt);
   endfunction

   task automatic model_reset();
      m_run = 0; m_step = 0; m_halt = 0; m_stepq = 0; m_drain = 0;
      m_nstall = 0; m_nflush = 0; m_ncycle = 0;
   endtask

   task automatic expect_now();
      bit live;
      live = (m_run || m_step) && !m_halt && m_drain == 0 && rst_n;
      e_stall = live && ((exmr && uses(exrd))
                || (br && exrw && uses(exrd))
                || (br && mmr && uses(mrd)));
      e_hd   = rst_n && m_halt;
      e_pe   = live || (rst_n && m_drain > 0);
      e_risk = e_stall || (rst_n && m_drain > 0);
      e_pcw  = live && !e_stall && !hlt;
      e_ifw  = e_pcw;
      e_fl   = e_pcw && tk;
   endtask

   task automatic check_all(string tag);
      expect_now();
      chk({tag, ".risk"}, risk, e_risk);
      chk({tag, ".pc_write"}, pcw, e_pcw);
      chk({tag, ".ifid_write"}, ifw, e_ifw);
      chk({tag, ".flush"}, fl, e_fl);
      chk({tag, ".pipe_en"}, pe, e_pe);
      chk({tag, ".halted"}, hd, e_hd);
`ifdef RISK_STATS_EN
      chkv({tag, ".stall_cnt"}, int'(c_stall), m_nstall);
      chkv({tag, ".flush_cnt"}, int'(c_flush), m_nflush);
      chkv({tag, ".cycle_cnt"}, int'(c_cycle), m_ncycle);
`endif
   endtask

   task automatic model_step();
      if (e_stall) m_nstall++;
      if (e_fl) m_nflush++;
      if (e_pe) m_ncycle++;
      if (m_halt) begin
      end else if (m_drain > 0) begin
         m_drain--;
         if (m_drain == 0) m_halt = 1;
      end else if (m_run || m_step) begin
         if (!e_stall && hlt) begin
            m_drain = PIPE_DRAIN; m_run = 0; m_step = 0;
         end else if (m_step) begin
            m_step = 0;
         end else begin
            m_run = en;
         end
      end else if (en) begin
         m_run = 1;
      end else if (step && !m_stepq) begin
         m_step = 1;
      end
      m_stepq = step;
   endtask

   // Called just after a negedge with inputs already applied.
   task automatic cyc(string tag);
      #1;
      check_all(tag);
      @(posedge clk);
      if (rst_n) model_step();
      else model_reset();
      @(negedge clk);
   endtask

   task automatic clear_in();
      br = 0; tk = 0; hlt = 0; exmr = 0; exrw = 0; mmr = 0;
      rs = 0; rt = 0; exrd = 0; mrd = 0;
   endtask

   task automatic async_reset();
      rst_n = 0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      int pe_seen;
      model_reset();
      clear_in();
      rst_n = 0; en = 1; step = 0;
      @(negedge clk);
      cyc("rst0");
      cyc("rst1");
      rst_n = 1;
      cyc("release");
      #1;
      chk("run_pe", pe, 1'b1);
      chk("run_pc", pcw, 1'b1);

      exmr = 1; exrd = 8; rt = 8;
      #1;
      chk("lu_risk", risk, 1'b1);
      chk("lu_pc", pcw, 1'b0);
      cyc("load_use");
      clear_in();
      cyc("after_lu");
      exmr = 1; exrd = 0; rt = 0; rs = 0;
      #1;
      chk("r0_risk", risk, 1'b0);
      cyc("load_r0");

      clear_in();
      br = 1; rs = 9; tk = 1; exmr = 1; exrw = 1; exrd = 9;
      #1;
      chk("br_ex_flush", fl, 1'b0);
      cyc("br_ex");
      exmr = 0; exrw = 0; exrd = 0; mmr = 1; mrd = 9;
      #1;
      chk("br_mem_risk", risk, 1'b1);
      cyc("br_mem");
      mmr = 0; mrd = 0;
      #1;
      chk("br_go_flush", fl, 1'b1);
      cyc("br_go");
      clear_in();

      en = 0;
      cyc("to_idle");
      step = 1;
      pe_seen = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (pe) pe_seen++;
         cyc("step_hold");
      end
      chkv("step_once", pe_seen, 1);
      step = 0;
      cyc("step_low");
      step = 1; en = 1;
      cyc("step_en");
      cyc("en_run");
      #1;
      chk("en_run_pe", pe, 1'b1);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            async_reset();
            continue;
         end
         en   = ($urandom_range(0, 3) != 0);
         step = $urandom_range(0, 1);
         rs   = NB_REG'($urandom_range(0, 3));
         rt   = NB_REG'($urandom_range(0, 3));
         exrd = NB_REG'($urandom_range(0, 3));
         mrd  = NB_REG'($urandom_range(0, 3));
         br   = $urandom_range(0, 1);
         tk   = $urandom_range(0, 1);
         exmr = $urandom_range(0, 1);
         exrw = $urandom_range(0, 1);
         mmr  = $urandom_range(0, 1);
         hlt  = ($urandom_range(0, 39) == 0);
         cyc("rand");
      end

      clear_in();
      async_reset();
      en = 1; step = 0;
      cyc("h_idle");
      hlt = 1;
      #1;
      chk("halt_pc", pcw, 1'b0);
      cyc("halt_id");
      hlt = 0;
      for (int i = 0; i < PIPE_DRAIN; i++) begin
         en = ~en; step = ~step;
         #1;
         chk("drain_risk", risk, 1'b1);
         cyc("drain");
      end
      #1;
      chk("halted", hd, 1'b1);
      en = 1; step = 1;
      cyc("halted_hold");
      async_reset();
      #1;
      chk("halted_clr", hd, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
